mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Consumes the decoder's MemRead / MemWrite / SaveMethod controls and the funct3 field.
- Performs the data-memory transaction over a req/ack bus, generates byte enables and lane-replicated store data, and sign/zero-extends load data.
- Sits between the EX-stage ALU result (address) and data memory. Stalls the pipeline while a transaction is outstanding.

Parameters:
- N, 32, datapath and address width (the byte-lane logic below is fixed for N=32)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- MemRead  in  1  load request from control unit
- MemWrite  in  1  store request from control unit
- SaveMethod  in  2  store size: 00 byte, 01 half, 10 word, 11 reserved
- LoadFunct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- Addr  in  N  byte address (ALU result)
- StoreData  in  N  rs2 value
- Stall  out  1  hold the pipeline
- LoadData  out  N  extended load result
- LoadValid  out  1  LoadData valid (one-cycle pulse)
- AccessErr  out  1  misaligned or illegal-encoding access
- bus_req  out  1  transaction request
- bus_we  out  1  1 = write
- bus_addr  out  N  word-aligned address ({Addr[N-1:2],2'b00})
- bus_be  out  4  byte enables
- bus_wdata  out  N  write data
- bus_rdata  in  N  read data, valid when bus_ack=1
- bus_ack  in  1  transaction complete

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - bus_req, bus_we, bus_be, bus_addr, bus_wdata, LoadData, LoadValid = 0.
  - Stall and AccessErr read 0, since they are combinational from IDLE with no command.
  - Reset mid-transaction drops bus_req immediately. Any late bus_ack is ignored.
- Command:
  - cmd = MemRead | MemWrite.
  - MemWrite has priority: both high is treated as a store.
- Size:
  - Store size comes from SaveMethod.
  - Load size comes from LoadFunct3[1:0] (00 byte, 01 half, 10 word).
- Error check, evaluated in IDLE:
  - half with Addr[0]=1
  - word with Addr[1:0]≠0
  - SaveMethod=11 on a store
  - LoadFunct3 ∈ {011,110,111} on a load
  - If any check fails: AccessErr=1 combinationally, no bus transaction, Stall=0, LoadValid=0. The pipeline proceeds and the trap is handled elsewhere.
- FSM states IDLE, BUSY, DONE:
  - IDLE: if cmd and no error → Stall=1 combinationally.
    - Register bus_addr, bus_we, bus_be, bus_wdata.
    - Latch Addr[1:0] and load type.
    - bus_req=1 from the next cycle; go to BUSY.
  - BUSY: Stall=1. bus_req and all bus outputs held stable until bus_ack=1 is sampled.
    - On ack: bus_req=0 next cycle.
    - For a load, register LoadData from bus_rdata.
    - Go to DONE.
  - DONE: Stall=0 and LoadValid=1 (loads only) for exactly one cycle.
    - Inputs are ignored, because the same instruction is still presented.
    - Go to IDLE.
- Minimum latency: command at cycle 0, ack in cycle 1, LoadValid/Stall=0 in cycle 2. Three cycles per access.
- Wait states are unbounded. There is no timeout.
- Byte enables and write data:
  - byte: be = 4'b0001 << Addr[1:0], wdata = {4{StoreData[7:0]}}
  - half: be = Addr[1] ? 4'b1100 : 4'b0011, wdata = {2{StoreData[15:0]}}
  - word: be = 4'b1111, wdata = StoreData
  - Loads: bus_we=0, be as per size, wdata=0.
- Load extraction:
  - byte lane = rdata[8*a+7:8*a], where a = latched Addr[1:0].
  - half = Addr[1] ? rdata[31:16] : rdata[15:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- bus_ack outside BUSY is ignored.
- LoadData holds its value after LoadValid falls.

Decomposition:
- Package mem_pkg holds:
  - SaveMethod codes (SM_BYTE/SM_HALF/SM_WORD)
  - load funct3 codes (LB, LH, LW, LBU, LHU)
  - the FSM state enum
- Sub-module load_aligner: combinational lane select and extension, taking rdata, addr_lo[1:0] and funct3, and producing the N-bit result.

Test Plan:
1. SW, Addr=0x104, StoreData=0xDEADBEEF, ack after 2 wait cycles → bus_addr=0x104, be=1111, wdata=0xDEADBEEF, bus_we=1. Stall high for 4 cycles. bus_req stable until ack.
2. SB, Addr=0x203, StoreData=0x000000A5, immediate ack → bus_addr=0x200, be=1000, wdata=0xA5A5A5A5. Stall 2 cycles.
3. Loads with rdata=0x80F17F82:
   - LB at Addr[1:0]=0 → 0xFFFFFF82
   - LBU at Addr[1:0]=0 → 0x00000082
   - LH at 0x2 → 0xFFFF80F1
   - LHU at 0x2 → 0x000080F1
   - LW → 0x80F17F82
   - LoadValid pulses one cycle, in DONE.
4. LW at Addr=0x102, SH at Addr=0x101, SaveMethod=11 → AccessErr=1 same cycle, bus_req stays 0, Stall=0.
5. rst_n low while BUSY → bus_req=0 immediately, state IDLE. A bus_ack after reset release produces no LoadValid.
6. Back-to-back: LW then SW on consecutive instructions, both with immediate ack → first completes in DONE. Second is captured in the following IDLE cycle, and there is no duplicate request for the first.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared codes for the data-memory access unit.
// Store sizes, load funct3 encodings and the access FSM states.
package mem_pkg;
  localparam logic [1:0] SM_BYTE = 2'b00;
  localparam logic [1:0] SM_HALF = 2'b01;
  localparam logic [1:0] SM_WORD = 2'b10;
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
endpackage

// File: rtl/load_aligner.sv
// load_aligner: selects the addressed byte/half lane of a read word and extends it.
// funct3[2] set means zero-extension; the size field is funct3[1:0].
module load_aligner
  import mem_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] rdata_i,
  input  logic [1:0]   addr_lo_i,
  input  logic [2:0]   funct3_i,
  output logic [N-1:0] data_o
);
  logic [7:0]  b;
  logic [15:0] h;
  logic        sb, sh;
  always_comb begin
    b      = rdata_i[8*addr_lo_i +: 8];
    h      = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    sb     = b[7] & ~funct3_i[2];
    sh     = h[15] & ~funct3_i[2];
    data_o = funct3_i[1:0] == LB[1:0] ? {{(N-8){sb}}, b} :
             funct3_i[1:0] == LH[1:0] ? {{(N-16){sh}}, h} : rdata_i;
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: runs one load/store per instruction over a req/ack bus,
// stalling the pipeline until the bus acknowledges.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         MemRead,
  input  logic         MemWrite,
  input  logic [1:0]   SaveMethod,
  input  logic [2:0]   LoadFunct3,
  input  logic [N-1:0] Addr,
  input  logic [N-1:0] StoreData,
  output logic         Stall,
  output logic [N-1:0] LoadData,
  output logic         LoadValid,
  output logic         AccessErr,
  output logic         bus_req,
  output logic         bus_we,
  output logic [N-1:0] bus_addr,
  output logic [3:0]   bus_be,
  output logic [N-1:0] bus_wdata,
  input  logic [N-1:0] bus_rdata,
  input  logic         bus_ack
);
  state_e       state_q, state_d;
  logic [N-1:0] addr_q, wdata_q, wdata_d, ld_q, aligned;
  logic [3:0]   be_q, be_d;
  logic [1:0]   lo_q, size;
  logic [2:0]   f3_q;
  logic         we_q, cmd, err, go;
  always_comb begin
    cmd     = MemRead | MemWrite;
    size    = MemWrite ? SaveMethod : LoadFunct3[1:0];
    err     = (MemWrite ? SaveMethod == 2'b11 : (LoadFunct3 == 3'b011 || LoadFunct3[2:1] == 2'b11))
            | (size == SM_HALF && Addr[0]) | (size == SM_WORD && Addr[1:0] != 2'b00);
    go      = state_q == IDLE && cmd && !err;
    state_d = state_q == IDLE ? (go ? BUSY : IDLE) :
              state_q == BUSY ? (bus_ack ? DONE : BUSY) : IDLE;
    be_d    = size == SM_BYTE ? 4'b0001 << Addr[1:0] :
              size == SM_HALF ? (Addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_d = !MemWrite ? '0 :
              size == SM_BYTE ? {4{StoreData[7:0]}} :
              size == SM_HALF ? {2{StoreData[15:0]}} : StoreData;
  end
  load_aligner #(.N(N)) u_align (
    .rdata_i   (bus_rdata),
    .addr_lo_i (lo_q),
    .funct3_i  (f3_q),
    .data_o    (aligned)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      f3_q    <= '0;
      ld_q    <= '0;
    end else begin
      state_q <= state_d;
      if (go) begin
        addr_q  <= {Addr[N-1:2], 2'b00};
        we_q    <= MemWrite;
        be_q    <= be_d;
        wdata_q <= wdata_d;
        lo_q    <= Addr[1:0];
        f3_q    <= LoadFunct3;
      end
      if (state_q == BUSY && bus_ack && !we_q) ld_q <= aligned;
    end
  end
  assign Stall     = go || state_q == BUSY;
  assign AccessErr = state_q == IDLE && cmd && err;
  assign LoadValid = state_q == DONE && !we_q;
  assign LoadData  = ld_q;
  assign bus_req   = state_q == BUSY;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_be    = be_q;
  assign bus_wdata = wdata_q;
endmodule
